// File: rtl/adc_result_framer_pkg.sv
// Shared constants and types for the ADC result framer: frame layout,
// result-word field positions and the framer state encoding.
package adc_result_framer_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_BYTES   = 8;
    localparam int         DATA_BYTES    = 6;
    localparam int         RES_W         = 48;

    // Result word layout: [47] zero, then runup count, sign, runup set, rundown count
    localparam int RUNUP_CNT_MSB    = 46;
    localparam int RUNUP_CNT_LSB    = 32;
    localparam int RUNDOWN_SIGN_BIT = 31;
    localparam int RUNUP_SET_MSB    = 30;
    localparam int RUNUP_SET_LSB    = 16;
    localparam int RUNDOWN_CNT_MSB  = 15;
    localparam int RUNDOWN_CNT_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        CSUM
    } frame_state_t;

endpackage

// File: rtl/adc_result_framer_res_fifo.sv
// Small synchronous FIFO buffering conversion results ahead of the framer.
// full/empty are registered from the post-edge occupancy.
module res_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign rd_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/adc_result_framer.sv
// Buffers 48-bit conversion results and serialises each as an 8-byte frame
// (sync, six data bytes MSB-first, XOR checksum) over a byte valid/ready link.
module adc_result_framer
    import adc_result_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [RES_W-1:0] res_data,
    input  logic             res_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             fifo_full,
    output logic [7:0]       drop_cnt,
    output logic             busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BYTES - 1);

    frame_state_t     state;
    frame_state_t     state_next;
    logic [RES_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic [RES_W-1:0] frame;
    logic [7:0]       csum;
    logic [2:0]       byte_idx;
    logic [7:0]       data_byte;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only the idle framer takes the head; a full FIFO still accepts a write on that edge.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = res_valid && (!fifo_full || pop);
    assign drop = res_valid && fifo_full && !pop;

    res_fifo #(
        .DATA_W (RES_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mclk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (res_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        case (byte_idx)
            3'd0:    data_byte = frame[47:40];
            3'd1:    data_byte = frame[39:32];
            3'd2:    data_byte = frame[31:24];
            3'd3:    data_byte = frame[23:16];
            3'd4:    data_byte = frame[15:8];
            default: data_byte = frame[7:0];
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = SYNC;
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) state_next = DATA;
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = data_byte;
                if (tx_ready && (byte_idx == LAST_IDX)) state_next = CSUM;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame register, running checksum and byte index; the sync byte is not summed.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            csum     <= 8'h00;
            byte_idx <= 3'd0;
        end else if (pop) begin
            frame    <= fifo_head;
            csum     <= 8'h00;
            byte_idx <= 3'd0;
        end else if ((state == DATA) && tx_ready) begin
            csum <= csum ^ data_byte;
            if (byte_idx != LAST_IDX) byte_idx <= byte_idx + 3'd1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_adc_result_framer.sv
// Randomised scoreboard bench for adc_result_framer: a queue-based model
// predicts accepted words and frame bytes; a negedge monitor checks the DUT.
module tb_adc_result_framer;

    localparam int FIFO_DEPTH = 2;

    logic        mclk;
    logic        rst_n;
    logic [47:0] res_data;
    logic        res_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fifo_full;
    logic [7:0]  drop_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [47:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    logic [7:0]  exp_q[$];
    int          m_drop = 0;

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    adc_result_framer #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .res_data  (res_data),
        .res_valid (res_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame = sync, six bytes MSB-first, XOR of those six bytes.
    function automatic logic [63:0] make_frame(input logic [47:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 6; i++) x = x ^ w[47-8*i -: 8];
        return {8'hA5, w, x};
    endfunction

    // Behavioural model: one frame in flight plus a FIFO of DEPTH words.
    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_cur.delete();
            exp_q.delete();
            m_drop = 0;
        end else begin
            bit          pop_now;
            bit          acc;
            logic [63:0] f;
            pop_now = (m_cur.size() == 0) && (m_fifo.size() != 0);
            acc     = res_valid && ((m_fifo.size() < FIFO_DEPTH) || pop_now);
            if (res_valid && !acc && m_drop < 255) m_drop++;
            if (m_cur.size() != 0 && tx_ready) begin
                void'(m_cur.pop_front());
            end else if (pop_now) begin
                f = make_frame(m_fifo.pop_front());
                for (int i = 0; i < 8; i++) m_cur.push_back(f[63-8*i -: 8]);
            end
            if (acc) begin
                m_fifo.push_back(res_data);
                f = make_frame(res_data);
                for (int i = 0; i < 8; i++) exp_q.push_back(f[63-8*i -: 8]);
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge mclk) begin
        if (!rst_n) begin
            chk("rst_tx_valid", 64'(tx_valid), 64'(0));
            chk("rst_tx_data", 64'(tx_data), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_fifo_full", 64'(fifo_full), 64'(0));
            chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
            prev_stall = 1'b0;
        end else begin
            chk("tx_valid", 64'(tx_valid), 64'(m_cur.size() != 0));
            chk("busy", 64'(busy), 64'(m_cur.size() != 0));
            chk("fifo_full", 64'(fifo_full), 64'(m_fifo.size() == FIFO_DEPTH));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (prev_stall) chk("stall_hold", 64'({tx_valid, tx_data}), 64'({1'b1, prev_data}));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte: got unexpected byte %0h, expected none at %0t", tx_data, $time);
                end else begin
                    chk("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic strobe(input logic [47:0] w);
        res_data  = w;
        res_valid = 1'b1;
        cyc(1);
        res_valid = 1'b0;
    endtask

    function automatic logic [47:0] rand_word();
        logic [47:0] w;
        w     = {16'($urandom()), $urandom()};
        w[47] = 1'b0;
        return w;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((m_cur.size() != 0 || m_fifo.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cyc(1);
            n++;
        end
        chk("drain_pending_bytes", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        tx_ready  = 1'b0;
        cyc(2);
        chk("reset_tx_valid", 64'(tx_valid), 64'(0));
        chk("reset_tx_data", 64'(tx_data), 64'(0));
        chk("reset_fifo_full", 64'(fifo_full), 64'(0));
        chk("reset_drop_cnt", 64'(drop_cnt), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        cyc(1);

        // Single frame at full rate.
        tx_ready = 1'b1;
        strobe(48'h0012_3456_789A);
        wait_drain(40);

        // Backpressure: ready toggles every cycle.
        strobe(48'h0012_3456_789A);
        for (int i = 0; i < 40; i++) begin
            tx_ready = (i % 2 == 0);
            cyc(1);
        end
        tx_ready = 1'b1;
        wait_drain(40);

        // Overflow: A in the framer, B and C fill the FIFO, D is dropped.
        tx_ready = 1'b0;
        strobe(48'h0000_0000_00AA);
        strobe(48'h0000_0000_00BB);
        strobe(48'h0000_0000_00CC);
        chk("ovf_fifo_full", 64'(fifo_full), 64'(1));
        strobe(48'h0000_0000_00DD);
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'(1));
        tx_ready = 1'b1;
        wait_drain(100);

        // Write into a full FIFO on the same edge as the idle pop.
        tx_ready = 1'b0;
        strobe(48'h1111_2222_3333);
        strobe(48'h4444_5555_6666);
        strobe(48'h7777_0000_1234);
        tx_ready = 1'b1;
        n = 0;
        while (!(m_cur.size() == 0 && m_fifo.size() == FIFO_DEPTH) && n < 50) begin
            cyc(1);
            n++;
        end
        strobe(48'h0ABC_DEF0_1357);
        chk("simul_drop_cnt", 64'(drop_cnt), 64'(1));
        chk("simul_fifo_full", 64'(fifo_full), 64'(1));
        wait_drain(100);

        // Random traffic and random backpressure.
        for (int i = 0; i < 600; i++) begin
            res_valid = ($urandom_range(0, 4) == 0);
            res_data  = rand_word();
            tx_ready  = 1'($urandom_range(0, 1));
            cyc(1);
        end
        res_valid = 1'b0;
        tx_ready  = 1'b1;
        wait_drain(200);

        // Drop counter saturation.
        tx_ready = 1'b0;
        repeat (300) strobe(rand_word());
        chk("sat_drop_cnt", 64'(drop_cnt), 64'(255));
        repeat (5) strobe(rand_word());
        chk("sat_drop_hold", 64'(drop_cnt), 64'(255));
        tx_ready = 1'b1;
        wait_drain(100);

        // Reset after the third byte of a frame, with the FIFO holding words.
        strobe(48'h0123_4567_89AB);
        strobe(48'h0CDE_F012_3456);
        strobe(48'h0789_ABCD_EF01);
        n = 0;
        while (m_cur.size() != 5 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("midrst_bytes_left", 64'(m_cur.size()), 64'(5));
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", 64'(tx_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_fifo_full", 64'(fifo_full), 64'(0));
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'(0));
        cyc(2);
        rst_n = 1'b1;
        cyc(30);
        chk("post_rst_tx_valid", 64'(tx_valid), 64'(0));
        strobe(48'h0055_AA55_AA55);
        wait_drain(40);

        chk("final_exp_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
